uart_txq: RTL and testbench
===========================

UART_TXQ -- requirements
Module: uart_txq

Interface
REQ-001 Parameter DATA_BITS, default 8, data bits per frame, legal 5..9.
REQ-002 Parameter FIFO_DEPTH, default 4, transmit FIFO entries, power of two, 2..16.
REQ-003 Parameter DIV_W, default 16, width of the runtime baud divisor.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 baud_div  input  DIV_W  clocks per bit; sampled at frame start.
REQ-007 stop2  input  1  1 = two stop bits, 0 = one; sampled at frame start.
REQ-008 parity_mode  input  2  00 none, 01 even, 10 odd, 11 none; sampled at frame start.
REQ-009 tx_data  input  DATA_BITS  word to transmit.
REQ-010 tx_valid  input  1  tx_data is valid.
REQ-011 tx_ready  output  1  FIFO can accept a word; high exactly when FIFO not full.
REQ-012 txd  output  1  serial line, idle high, registered.
REQ-013 busy  output  1  high from first start-bit cycle through last stop-bit cycle.
REQ-014 fifo_level  output  $clog2(FIFO_DEPTH)+1  words held in FIFO, 0..FIFO_DEPTH.

Function
REQ-015 Word SHALL be accepted on a rising edge where tx_valid & tx_ready; no other edge writes the FIFO.
REQ-016 FIFO full: tx_ready low, tx_valid ignored, no overwrite; pop-and-push in the same cycle while full is not permitted (ready already low).
REQ-017 FSM states IDLE, START, DATA, PARITY, STOP; IDLE -> START when FIFO non-empty, popping the head word on that edge.
REQ-018 Idle and empty FIFO: txd SHALL fall on the edge after the accepting edge (one-cycle latency).
REQ-019 Each bit SHALL last exactly max(baud_div,2) clocks; baud_div, stop2, parity_mode latched on the pop edge; changes mid-frame have no effect.
REQ-020 Frame order: one start bit 0, DATA_BITS data LSB first, optional parity bit, 1 or 2 stop bits 1.
REQ-021 Parity bit: even = XOR of data bits; odd = its inverse; parity_mode 00/11 skips PARITY state.
REQ-022 If FIFO non-empty at the last stop-bit cycle, next start bit SHALL begin on the following cycle (no idle gap); else return to IDLE, txd high.
REQ-023 fifo_level SHALL be incremented on push, decremented on pop, unchanged on simultaneous push and pop; pointers wrap modulo FIFO_DEPTH.
REQ-024 busy SHALL stay high continuously across back-to-back frames.

Reset
REQ-025 rst_n low SHALL immediately force txd=1, busy=0, fifo_level=0, tx_ready=1, FSM=IDLE, pointers 0, bit counter and divider 0.
REQ-026 Reset mid-frame SHALL abort the frame and discard FIFO contents; no partial frame resumes after release.
REQ-027 tx_valid SHALL be ignored while rst_n is low; first acceptance possible on the first edge after release.

Configuration
REQ-028 Macro UART_TXQ_PARITY_EN defined: parity per REQ-021.
REQ-029 Macro UART_TXQ_PARITY_EN undefined: PARITY state and parity logic SHALL be absent, parity_mode port kept but ignored, frames always without parity.

Verification
REQ-030 baud_div=4, stop2=0, parity none, push 0x55 while idle -> txd low 1 cycle after accept, then 0,1,0,1,0,1,0,1,0,1 each 4 clocks, 40 clocks total, busy high throughout.
REQ-031 PARITY_EN, baud_div=4, push 0x07 even then 0x07 odd -> parity bit 1 then 0, frames back-to-back with no idle cycle between.
REQ-032 baud_div=100, FIFO_DEPTH=4, tx_valid held high with 6 words -> first popped, 4 queued, tx_ready low after 5th accept, 6th accepted on the pop edge after first frame, fifo_level never exceeds 4.
REQ-033 stop2=1, baud_div=3, push 0xA0 -> stop phase 6 clocks high; baud_div=1 -> every bit 2 clocks.
REQ-034 rst_n pulsed low mid-data-bit with 3 words queued -> txd=1, busy=0, fifo_level=0 same cycle; no txd activity after release until new push.
REQ-035 baud_div changed 4 -> 8 mid-frame -> current frame keeps 4-clock bits, next frame uses 8.

Source files
------------

// File: rtl/uart_txq.sv
// uart_txq: UART transmitter with a small FIFO, runtime divisor, 1/2 stop bits.
// Parity is built in only when UART_TXQ_PARITY_EN is defined.
module uart_txq #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic                          stop2,
  input  logic [1:0]                    parity_mode,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP
`ifdef UART_TXQ_PARITY_EN
    , PARITY
`endif
  } state_t;
  state_t               state_q, state_d;
  logic [DIV_W-1:0]     cnt_q, cnt_d, len_q, len_d;
  logic [3:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 stop2_q, stop2_d;
  logic                 txd_q, txd_d;
  logic [AW-1:0]        wp_q, rp_q;
  logic [LW-1:0]        lvl_q;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic                 push, pop, bit_end;
`ifdef UART_TXQ_PARITY_EN
  logic                 par_en_q, par_en_d, par_q, par_d;
`else
  logic                 unused_parity;
  assign unused_parity = ^parity_mode;
`endif
  assign tx_ready   = lvl_q != LW'(FIFO_DEPTH);
  assign push       = tx_valid & tx_ready;
  assign bit_end    = cnt_q == len_q - DIV_W'(1);
  assign txd        = txd_q;
  assign busy       = state_q != IDLE;
  assign fifo_level = lvl_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = bit_end ? '0 : cnt_q + DIV_W'(1);
    len_d   = len_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    stop2_d = stop2_q;
    pop     = 1'b0;
`ifdef UART_TXQ_PARITY_EN
    par_en_d = par_en_q;
    par_d    = par_q;
`endif
    case (state_q)
      IDLE: cnt_d = '0;
      START: if (bit_end) begin
        state_d = DATA;
        idx_d   = '0;
      end
      DATA: if (bit_end) begin
        sh_d  = sh_q >> 1;
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'(DATA_BITS - 1)) begin
          idx_d = '0;
`ifdef UART_TXQ_PARITY_EN
          state_d = par_en_q ? PARITY : STOP;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_TXQ_PARITY_EN
      PARITY: if (bit_end) begin
        state_d = STOP;
        idx_d   = '0;
      end
`endif
      STOP: if (bit_end) begin
        idx_d   = idx_q + 4'd1;
        state_d = (idx_q == {3'b0, stop2_q}) ? IDLE : STOP;
      end
      default: state_d = IDLE;
    endcase
    // A frame ending with data queued chains straight into the next start bit.
    if (state_d == IDLE && lvl_q != '0) begin
      pop     = 1'b1;
      state_d = START;
      cnt_d   = '0;
      idx_d   = '0;
      len_d   = (baud_div < DIV_W'(2)) ? DIV_W'(2) : baud_div;
      stop2_d = stop2;
      sh_d    = mem[rp_q];
`ifdef UART_TXQ_PARITY_EN
      par_en_d = ^parity_mode;
      par_d    = (^mem[rp_q]) ^ parity_mode[1];
`endif
    end
    txd_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? sh_d[0] : 1'b1;
`ifdef UART_TXQ_PARITY_EN
    if (state_d == PARITY) txd_d = par_q;
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      stop2_q <= 1'b0;
      txd_q   <= 1'b1;
      wp_q    <= '0;
      rp_q    <= '0;
      lvl_q   <= '0;
`ifdef UART_TXQ_PARITY_EN
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      stop2_q <= stop2_d;
      txd_q   <= txd_d;
      wp_q    <= push ? wp_q + AW'(1) : wp_q;
      rp_q    <= pop ? rp_q + AW'(1) : rp_q;
      lvl_q   <= lvl_q + LW'(push) - LW'(pop);
`ifdef UART_TXQ_PARITY_EN
      par_en_q <= par_en_d;
      par_q    <= par_d;
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wp_q] <= tx_data;
  end
endmodule

// File: tb/tb_uart_txq.sv
// tb_uart_txq: directed bench for uart_txq (8 data bits, 4-deep FIFO).
module tb_uart_txq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] baud_div = 16'd4;
  logic        stop2 = 1'b0;
  logic [1:0]  parity_mode = 2'b00;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_valid = 1'b0;
  logic        tx_ready, txd, busy;
  logic [2:0]  fifo_level;
  int          errs = 0;
  int          checks = 0;
  logic [2:0]  max_lvl = '0;

  uart_txq #(.DATA_BITS(8), .FIFO_DEPTH(4), .DIV_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .stop2(stop2),
    .parity_mode(parity_mode), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .txd(txd), .busy(busy), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (fifo_level > max_lvl) max_lvl = fifo_level;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; the word is accepted on the following posedge.
  task automatic push(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Checks every cycle of a frame, starting at the current negedge (first start-bit cycle).
  task automatic frame(input logic [7:0] d, input int len, input bit two, input int par);
    logic [15:0] bits;
    int n;
    bits = '0;
    n = 1;
    for (int i = 0; i < 8; i++) begin bits[n] = d[i]; n++; end
    if (par >= 0) begin bits[n] = par[0]; n++; end
    bits[n] = 1'b1; n++;
    if (two) begin bits[n] = 1'b1; n++; end
    for (int i = 0; i < n; i++)
      for (int j = 0; j < len; j++) begin
        chk($sformatf("txd %02h bit%0d cyc%0d", d, i, j), txd, bits[i]);
        chk($sformatf("busy %02h bit%0d", d, i), busy, 1);
        @(negedge clk);
      end
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, " txd"}, txd, 1);
    chk({tag, " busy"}, busy, 0);
  endtask

  initial begin
    int k;
    bit low_seen;
    tx_valid = 1'b1;
    tx_data  = 8'hEE;
    repeat (3) @(negedge clk);
    chk("rst txd", txd, 1);
    chk("rst busy", busy, 0);
    chk("rst level", fifo_level, 0);
    chk("rst ready", tx_ready, 1);
    tx_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    idle_chk("post rst");

    // 0x55, 8N1, 4 clocks per bit
    push(8'h55);
    idle_chk("latency");
    @(negedge clk);
    frame(8'h55, 4, 0, -1);
    idle_chk("after 55");

    // Two stop bits at divisor 3
    baud_div = 16'd3; stop2 = 1'b1;
    push(8'hA0);
    @(negedge clk);
    frame(8'hA0, 3, 1, -1);
    idle_chk("after A0");

    // Divisor 1 is clamped to 2 clocks per bit
    baud_div = 16'd1; stop2 = 1'b0;
    push(8'h3C);
    @(negedge clk);
    frame(8'h3C, 2, 0, -1);
    idle_chk("after 3C");

    // Back-to-back frames; divisor change mid-frame applies to the next frame only
    baud_div = 16'd4;
    push(8'h81);
    push(8'h6E);
    baud_div = 16'd8;
    frame(8'h81, 4, 0, -1);
    frame(8'h6E, 8, 0, -1);
    idle_chk("after 6E");

`ifdef UART_TXQ_PARITY_EN
    baud_div = 16'd4;
    parity_mode = 2'b01;
    push(8'h07);
    push(8'h07);
    parity_mode = 2'b10;
    frame(8'h07, 4, 0, 1);
    frame(8'h07, 4, 0, 0);
    idle_chk("after parity");
    parity_mode = 2'b00;
`else
    baud_div = 16'd4;
    parity_mode = 2'b01;
    push(8'h07);
    @(negedge clk);
    frame(8'h07, 4, 0, -1);
    idle_chk("no parity");
    parity_mode = 2'b00;
`endif

    // FIFO fill with tx_valid held high at divisor 100
    baud_div = 16'd100;
    max_lvl = '0;
    tx_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tx_data = 8'h10 + 8'(i);
      @(negedge clk);
    end
    chk("full level", fifo_level, 4);
    chk("full ready", tx_ready, 0);
    chk("full busy", busy, 1);
    tx_data = 8'h15;
    k = 0;
    while (!tx_ready && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("ready wait", k, 997);
    chk("level after pop", fifo_level, 3);
    @(negedge clk);
    tx_valid = 1'b0;
    chk("refill level", fifo_level, 4);
    chk("refill ready", tx_ready, 0);
    chk("level max", max_lvl, 4);

    // Reset mid data bit with the FIFO full
    repeat (250) @(negedge clk);
    chk("pre-rst busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("async txd", txd, 1);
    chk("async busy", busy, 0);
    chk("async level", fifo_level, 0);
    chk("async ready", tx_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    low_seen = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (!txd || busy) low_seen = 1'b1;
    end
    chk("quiet after rst", low_seen, 0);
    chk("level after rst", fifo_level, 0);

    baud_div = 16'd4;
    push(8'hC3);
    @(negedge clk);
    frame(8'hC3, 4, 0, -1);
    idle_chk("final");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
